// File: rtl/button_pkg.sv
// Shared button indices, direction encodings and default timing constants for
// the button front end and the navigation state machine.
package button_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_T = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 12500000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  // Fixed priority T > R > D > L when several pulses land in one cycle.
  function automatic dir_e prio_dir(input logic [3:0] press);
    if (press[BTN_T])      return DIR_UP;
    else if (press[BTN_R]) return DIR_RIGHT;
    else if (press[BTN_D]) return DIR_DOWN;
    else if (press[BTN_L]) return DIR_LEFT;
    else                   return DIR_UP;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce counter and press pulse.
// Auto-repeat hold counter is built only when BUTTON_AUTO_REPEAT_EN is defined.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 5
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic press_d_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q;
  logic                   press_q, press_d;
  logic                   sync_s;
  logic                   rise_s;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise_s = level_q & ~level_prev_q;

  // Any cycle agreeing with the stable level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_s != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
      else                                      cnt_d   = cnt_q + 1'b1;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rpt_s;

  // Down-counter armed by the initial pulse; terminal count fires a repeat and reloads.
  always_comb begin
    hold_d = '0;
    rpt_s  = 1'b0;
    if (level_q && level_d) begin
      if (rise_s) begin
        hold_d = HOLD_W'(REPEAT_DELAY - 1);
      end else if (hold_q == '0) begin
        rpt_s  = 1'b1;
        hold_d = HOLD_W'(REPEAT_PERIOD - 1);
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hold_q <= '0;
    else         hold_q <= hold_d;
  end

  assign press_d = rise_s | rpt_s;
`else
  assign press_d = rise_s;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign press_d_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Four-button front end: debounced levels, press pulses, last direction pressed.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BTN_RAW,
  output logic [3:0] BTN_LEVEL,
  output logic [3:0] BTN_PRESS,
  output logic       ANY_PRESS,
  output logic [1:0] LAST_DIR,
  output logic       DIR_VALID
);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_conditioner: illegal timing parameter");
  end

  logic [3:0] press_d;
  logic       any_d;
  logic       any_q;
  dir_e       last_dir_q;
  logic       dir_valid_q;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i    (CLK),
      .rst_ni   (RESET),
      .raw_i    (BTN_RAW[i]),
      .level_o  (BTN_LEVEL[i]),
      .press_o  (BTN_PRESS[i]),
      .press_d_o(press_d[i])
    );
  end

  assign any_d = |press_d;

  // Registered from the channels' next-pulse so these line up with BTN_PRESS.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      any_q       <= 1'b0;
      last_dir_q  <= DIR_UP;
      dir_valid_q <= 1'b0;
    end else begin
      any_q       <= any_d;
      dir_valid_q <= dir_valid_q | any_d;
      if (any_d) last_dir_q <= prio_dir(press_d);
    end
  end

  assign ANY_PRESS = any_q;
  assign LAST_DIR  = last_dir_q;
  assign DIR_VALID = dir_valid_q;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that sits directly upstream of the game top level, between the four raw board push-buttons and the BTNL/BTNT/BTNR/BTND inputs.
- Per button: synchronises, debounces, and produces a clean level plus a one-cycle press pulse.
- Also keeps a registered "last direction pressed" code, so downstream state machines see glitch-free, single-event inputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the stable level before the stable level flips (10 ms at 100 MHz); legal values are 2 and up.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal values are 2 and up.
- REPEAT_DELAY, 50000000, cycles a held button waits before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 12500000, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-low reset.
- BTN_RAW  input  4  raw asynchronous buttons; bit0=L, bit1=T, bit2=R, bit3=D.
- BTN_LEVEL  output  4  debounced stable level per button, same bit order.
- BTN_PRESS  output  4  one-cycle pulse per button on each debounced press (and each repeat, if enabled).
- ANY_PRESS  output  1  OR of BTN_PRESS, registered in the same cycle.
- LAST_DIR  output  2  most recent pressed direction: 00=T, 01=R, 10=D, 11=L.
- DIR_VALID  output  1  high once any press has occurred since reset.

Behaviour:
- Reset (RESET low, asynchronous): synchroniser flops, BTN_LEVEL, BTN_PRESS, ANY_PRESS, counters and DIR_VALID all go to 0; LAST_DIR goes to 00. All outputs are registered.
- Synchroniser: each BTN_RAW bit passes through SYNC_STAGES flops; the last stage is sync[i].
- Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES):
  - sync[i] equals BTN_LEVEL[i]: counter clears to 0.
  - sync[i] differs and counter equals DEBOUNCE_CYCLES-1: BTN_LEVEL[i] toggles and counter clears.
  - Otherwise: counter increments.
  - Any single-cycle agreement with the stable level restarts the count. This is the glitch rejection.
- Latency: a clean raw transition held steady shows on BTN_LEVEL exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new value.
- BTN_PRESS[i]: high for exactly one cycle, in the cycle after BTN_LEVEL[i] goes 0->1. A release (1->0) produces no pulse.
- LAST_DIR: updates in the same cycle BTN_PRESS is high.
  - Simultaneous presses resolve by fixed priority T > R > D > L.
  - Holds its value when no press occurs.
- DIR_VALID: set on the first ANY_PRESS; cleared only by reset.
- Button held indefinitely: BTN_LEVEL stays 1 and no further pulses are produced (without the feature).
- Reset asserted mid-debounce: the count is discarded. After release, a still-pressed button needs a full SYNC_STAGES+DEBOUNCE_CYCLES before its pulse.

Optional Feature:
- Macro name: BUTTON_AUTO_REPEAT_EN.
- When defined:
  - Each channel gets a hold counter, active while BTN_LEVEL[i]=1.
  - An extra BTN_PRESS[i] pulse fires REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles until release.
  - Release clears the hold counter immediately.
  - Repeat pulses update LAST_DIR and ANY_PRESS exactly like normal presses.
- When not defined: no hold counters are synthesised, and exactly one pulse is produced per press.

Decomposition:
- Shared package button_pkg holds:
  - bit-index constants BTN_L=0, BTN_T=1, BTN_R=2, BTN_D=3;
  - 2-bit direction encodings DIR_UP=00, DIR_RIGHT=01, DIR_DOWN=10, DIR_LEFT=11 (shared with the navigation state machine);
  - the default debounce/repeat constants.
- One sub-module, debounce_channel, instantiated four times. It contains the synchroniser, debounce counter, edge pulse and optional repeat logic.
- The top level holds only the priority encoder, ANY_PRESS, LAST_DIR and DIR_VALID.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Reset: hold RESET low with BTN_RAW=4'b1111 -> all outputs 0 and LAST_DIR=00; after release, no pulse until 6 edges have elapsed.
- Clean press: BTN_RAW[2] goes 0->1 and is held -> BTN_LEVEL[2]=1 on edge 6, then BTN_PRESS=4'b0100 for one cycle, ANY_PRESS=1, LAST_DIR=01, DIR_VALID=1.
- Bounce: BTN_RAW[0] toggles 1,0,1,0,1 on alternate cycles, then stays 1 -> exactly one BTN_PRESS[0] pulse, 6 edges after the final rise; LAST_DIR=11.
- Simultaneous press: BTN_RAW goes 0000->1011 in one cycle -> BTN_PRESS=1011 pulsed together, LAST_DIR=00 (T wins).
- Release: button held, then released -> BTN_LEVEL falls 6 edges later with no BTN_PRESS pulse; pulse a 3-cycle raw glitch while idle -> no change on BTN_LEVEL.
- BUTTON_AUTO_REPEAT_EN build: hold BTN_RAW[3] for 40 cycles past the first pulse -> pulses at +0, +10, +15, +20, ... until release, each setting LAST_DIR=10. Non-feature build, same stimulus -> a single pulse.
